// File: rtl/output_wrapper_pkg.sv
// Shared types and sizing for the divider output stage.
package output_wrapper_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BUS_W  = 8;
  localparam int unsigned BPW    = DATA_W / BUS_W;
  localparam int unsigned NBYTES = 2 * DATA_W / BUS_W;
  localparam int unsigned CNT_W  = $clog2(NBYTES);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ow_state_t;

endpackage

// File: rtl/ow_byte_mux.sv
// Byte selector for the output buffer {Quotient, Remainder}.
// Build option OUTPUT_WRAPPER_LSB_FIRST_EN: send each word low byte first
// instead of the default high byte first.
module ow_byte_mux
  import output_wrapper_pkg::*;
(
  input  logic [2*DATA_W-1:0] buf_i,
  input  logic [CNT_W-1:0]    sel_i,
  output logic [BUS_W-1:0]    byte_o
);

  logic [BUS_W-1:0] bytes [NBYTES];

  // Map transfer index k to its byte slot in the buffer (slot 0 = buffer LSBs).
  for (genvar k = 0; k < NBYTES; k++) begin : g_slot
`ifdef OUTPUT_WRAPPER_LSB_FIRST_EN
    localparam int unsigned SLOT = (1 - (k / BPW)) * BPW + (k % BPW);
`else
    localparam int unsigned SLOT = NBYTES - 1 - k;
`endif
    assign bytes[k] = buf_i[SLOT*BUS_W +: BUS_W];
  end

  assign byte_o = bytes[sel_i];

endmodule

// File: rtl/output_wrapper.sv
// Bus-side output stage of the restoring divider: captures a Quotient/Remainder
// pair on Ready and serialises it one byte per accepted transfer.
// Byte order is selected by OUTPUT_WRAPPER_LSB_FIRST_EN (see ow_byte_mux).
module output_wrapper
  import output_wrapper_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              Ready,
  input  logic              ReceiveData,
  input  logic [DATA_W-1:0] Quotient,
  input  logic [DATA_W-1:0] Remainder,
  output logic              ReadyForInput,
  output logic              OutBuffFull,
  output logic [BUS_W-1:0]  DataOut
);

  ow_state_t           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] buf_q, buf_d;
  logic [BUS_W-1:0]    sel_byte;

  // State, counter and buffer registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  // Next-state logic: capture when idle, advance one byte per accepted transfer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        if (Ready) begin
          buf_d   = {Quotient, Remainder};
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ReceiveData) begin
          if (cnt_q == CNT_W'(NBYTES - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags and bus byte decoded from the registered state.
  always_comb begin
    ReadyForInput = 1'b1;
    OutBuffFull   = 1'b0;
    DataOut       = '0;
    if (state_q == SEND) begin
      ReadyForInput = 1'b0;
      OutBuffFull   = 1'b1;
      DataOut       = sel_byte;
    end
  end

  ow_byte_mux u_byte_mux (
    .buf_i  (buf_q),
    .sel_i  (cnt_q),
    .byte_o (sel_byte)
  );

endmodule

// File: tb/tb_output_wrapper.sv
// Directed self-checking bench for output_wrapper.
module tb_output_wrapper;

  logic        clk;
  logic        reset;
  logic        Ready;
  logic        ReceiveData;
  logic [15:0] Quotient;
  logic [15:0] Remainder;
  logic        ReadyForInput;
  logic        OutBuffFull;
  logic [7:0]  DataOut;

  int total;
  int bad;

  output_wrapper dut (
    .clk           (clk),
    .reset         (reset),
    .Ready         (Ready),
    .ReceiveData   (ReceiveData),
    .Quotient      (Quotient),
    .Remainder     (Remainder),
    .ReadyForInput (ReadyForInput),
    .OutBuffFull   (OutBuffFull),
    .DataOut       (DataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected k-th transmitted byte of a Q/R pair for the configured order.
  function automatic logic [7:0] exp_byte(input logic [15:0] q, input logic [15:0] r,
                                          input int k);
`ifdef OUTPUT_WRAPPER_LSB_FIRST_EN
    case (k)
      0:       return q[7:0];
      1:       return q[15:8];
      2:       return r[7:0];
      default: return r[15:8];
    endcase
`else
    case (k)
      0:       return q[15:8];
      1:       return q[7:0];
      2:       return r[15:8];
      default: return r[7:0];
    endcase
`endif
  endfunction

  // Advance one clock; leave time so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic rfi, input logic full,
                     input logic [7:0] d);
    logic [9:0] obs;
    logic [9:0] req;
    obs = {ReadyForInput, OutBuffFull, DataOut};
    req = {rfi, full, d};
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed rfi=%b full=%b data=%h expected rfi=%b full=%b data=%h",
             tag, obs[9], obs[8], obs[7:0], req[9], req[8], req[7:0]);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] d);
    chk(tag, 1'b0, 1'b1, d);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset       = 1'b0;
    Ready       = 1'b0;
    ReceiveData = 1'b0;
    Quotient    = 16'h0000;
    Remainder   = 16'h0000;
    #2;

    // 1: reset
    tick();
    chk_idle("reset");

    // 2: full-speed transfer of 0x1234 / 0xABCD
    reset       = 1'b1;
    Quotient    = 16'h1234;
    Remainder   = 16'hABCD;
    Ready       = 1'b1;
    ReceiveData = 1'b1;
    tick();
    Ready = 1'b0;
    chk_byte("t2_b0", exp_byte(16'h1234, 16'hABCD, 0));
    tick(); chk_byte("t2_b1", exp_byte(16'h1234, 16'hABCD, 1));
    tick(); chk_byte("t2_b2", exp_byte(16'h1234, 16'hABCD, 2));
    tick(); chk_byte("t2_b3", exp_byte(16'h1234, 16'hABCD, 3));
    tick(); chk_idle("t2_idle");
    // ReceiveData while idle must not start anything
    tick(); chk_idle("t2_rd_in_idle");

    // 3: backpressure for 3 cycles after capture
    ReceiveData = 1'b0;
    Ready       = 1'b1;
    tick();
    Ready = 1'b0;
    chk_byte("t3_cap", exp_byte(16'h1234, 16'hABCD, 0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_byte("t3_hold", exp_byte(16'h1234, 16'hABCD, 0));
    end
    ReceiveData = 1'b1;
    tick(); chk_byte("t3_b1", exp_byte(16'h1234, 16'hABCD, 1));
    tick(); chk_byte("t3_b2", exp_byte(16'h1234, 16'hABCD, 2));
    tick(); chk_byte("t3_b3", exp_byte(16'h1234, 16'hABCD, 3));
    tick(); chk_idle("t3_idle");

    // 4: Ready held into SEND with a changed quotient is ignored
    Ready = 1'b1;
    tick();
    chk_byte("t4_b0", exp_byte(16'h1234, 16'hABCD, 0));
    Quotient = 16'h5555;
    tick();
    Ready = 1'b0;
    chk_byte("t4_b1", exp_byte(16'h1234, 16'hABCD, 1));
    tick(); chk_byte("t4_b2", exp_byte(16'h1234, 16'hABCD, 2));
    tick(); chk_byte("t4_b3", exp_byte(16'h1234, 16'hABCD, 3));
    tick(); chk_idle("t4_idle");

    // 4b: Ready on the last-byte edge only returns to IDLE; capture follows
    Quotient  = 16'h0102;
    Remainder = 16'h0304;
    Ready     = 1'b1;
    tick();
    Ready = 1'b0;
    chk_byte("t4b_b0", exp_byte(16'h0102, 16'h0304, 0));
    tick(); tick();
    chk_byte("t4b_b2", exp_byte(16'h0102, 16'h0304, 2));
    tick();
    chk_byte("t4b_b3", exp_byte(16'h0102, 16'h0304, 3));
    Ready     = 1'b1;
    Quotient  = 16'hBEEF;
    Remainder = 16'hCAFE;
    tick(); chk_idle("t4b_last_idle");
    tick();
    Ready = 1'b0;
    chk_byte("t4b_recap_b0", exp_byte(16'hBEEF, 16'hCAFE, 0));
    tick(); chk_byte("t4b_recap_b1", exp_byte(16'hBEEF, 16'hCAFE, 1));
    tick(); chk_byte("t4b_recap_b2", exp_byte(16'hBEEF, 16'hCAFE, 2));
    tick(); chk_byte("t4b_recap_b3", exp_byte(16'hBEEF, 16'hCAFE, 3));
    tick(); chk_idle("t4b_idle");

    // 5: reset after the second byte aborts the transfer
    Quotient  = 16'h1234;
    Remainder = 16'hABCD;
    Ready     = 1'b1;
    tick();
    Ready = 1'b0;
    chk_byte("t5_b0", exp_byte(16'h1234, 16'hABCD, 0));
    tick(); chk_byte("t5_b1", exp_byte(16'h1234, 16'hABCD, 1));
    reset = 1'b0;
    tick(); chk_idle("t5_reset");
    reset     = 1'b1;
    Quotient  = 16'h00FF;
    Remainder = 16'h0001;
    Ready     = 1'b1;
    tick();
    Ready = 1'b0;
    chk_byte("t5_new_b0", exp_byte(16'h00FF, 16'h0001, 0));
    tick(); chk_byte("t5_new_b1", exp_byte(16'h00FF, 16'h0001, 1));
    tick(); chk_byte("t5_new_b2", exp_byte(16'h00FF, 16'h0001, 2));
    tick(); chk_byte("t5_new_b3", exp_byte(16'h00FF, 16'h0001, 3));
    tick(); chk_idle("t5_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
